// File: rtl/bounded_counter.sv
// Up/down counter bounded by [min_value, max_value] with wrap, saturate and
// one-shot behaviour at the bounds; one-shot parks in DONE until reloaded or re-moded.
module bounded_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              count_up,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  min_value,
    input  logic [WIDTH-1:0]  max_value,
    input  logic [WIDTH-1:0]  init_value,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    output logic [WIDTH-1:0]  count,
    output logic              at_min,
    output logic              at_max,
    output logic              wrap_pulse,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               wrap_q, wrap_d;

    logic [STEP_W-1:0]  step_nz;
    logic [WIDTH:0]     step_ext;
    logic [WIDTH:0]     cand_up;
    logic [WIDTH:0]     cand_dn;
    logic               in_range;
    logic               step_ok;
    logic [WIDTH-1:0]   step_val;
    logic [WIDTH-1:0]   clamp_tgt;
    logic [WIDTH-1:0]   wrap_tgt;

    assign step_nz  = (step == '0) ? STEP_W'(1) : step;
    assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step_nz};
    assign cand_up  = {1'b0, count_q} + step_ext;
    assign cand_dn  = {1'b0, count_q} - step_ext;
    assign in_range = (count_q >= min_value) && (count_q <= max_value);

    // A count already outside the window always takes the bound-crossing path.
    always_comb begin
        step_ok   = 1'b0;
        step_val  = count_q;
        clamp_tgt = min_value;
        wrap_tgt  = max_value;
        if (count_up) begin
            step_ok   = in_range && (cand_up <= {1'b0, max_value});
            step_val  = cand_up[WIDTH-1:0];
            clamp_tgt = max_value;
            wrap_tgt  = min_value;
        end else begin
            step_ok   = in_range && !cand_dn[WIDTH] && (cand_dn[WIDTH-1:0] >= min_value);
            step_val  = cand_dn[WIDTH-1:0];
        end
    end

    always_comb begin
        count_d = count_q;
        state_d = state_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_value;
            state_d = RUN;
        end else if (cfg_err) begin
            count_d = count_q;
        end else if (state_q == DONE) begin
            if (mode != MODE_ONESHOT) begin
                state_d = RUN;
            end
        end else if (enable) begin
            if (step_ok) begin
                count_d = step_val;
            end else begin
                case (mode)
                    MODE_WRAP: begin
                        count_d = wrap_tgt;
                        wrap_d  = 1'b1;
                    end
                    MODE_ONESHOT: begin
                        count_d = clamp_tgt;
                        wrap_d  = 1'b1;
                        state_d = DONE;
                    end
                    default: begin
                        count_d = clamp_tgt;
                        wrap_d  = (count_q != clamp_tgt);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= init_value;
            state_q <= RUN;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count      = count_q;
    assign wrap_pulse = wrap_q;
    assign done       = (state_q == DONE);
    assign at_min     = (count_q == min_value);
    assign at_max     = (count_q == max_value);
    assign cfg_err    = (min_value > max_value);

endmodule
